// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: drives the instruction memory request and owns the IF/ID pipeline register.
// Handles load-use stalls, branch redirects and discarding stale responses after a redirect.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IF_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ID_PC_plus4,
  output logic [31:0] ID_Instruction,
  output logic        ID_valid
);

  typedef enum logic [1:0] {FETCH, DROP, FULL} state_t;

  state_t      state_reg;
  logic [31:0] pc_reg;
  logic [31:0] drop_addr_reg;
  logic [31:0] buf_pc4_reg;
  logic [31:0] buf_instr_reg;
  logic        pending_reg;

  logic [31:0] pc_plus4;
  logic [31:0] target_aligned;
  logic        done;

  assign pc_plus4       = pc_reg + 32'd4;
  assign target_aligned = {redirect_target[31:2], 2'b00};

  // A request already outstanding must stay up until ready, even under stall.
  assign imem_req  = reset & ((state_reg == DROP) |
                              ((state_reg == FETCH) & (pending_reg | ~IF_stall)));
  assign imem_addr = (state_reg == DROP) ? drop_addr_reg : pc_reg;
  assign done      = imem_req & imem_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= FETCH;
      pc_reg         <= RESET_PC;
      drop_addr_reg  <= 32'd0;
      buf_pc4_reg    <= 32'd0;
      buf_instr_reg  <= 32'd0;
      pending_reg    <= 1'b0;
      ID_PC_plus4    <= 32'd0;
      ID_Instruction <= 32'd0;
      ID_valid       <= 1'b0;
    end else if (redirect) begin
      ID_PC_plus4    <= 32'd0;
      ID_Instruction <= 32'd0;
      ID_valid       <= 1'b0;
      pc_reg         <= target_aligned;
      buf_pc4_reg    <= 32'd0;
      buf_instr_reg  <= 32'd0;
      pending_reg    <= 1'b0;
      // The in-flight response belongs to the old path; wait it out in DROP.
      if (imem_req && !imem_ready) begin
        state_reg <= DROP;
        if (state_reg == FETCH) drop_addr_reg <= pc_reg;
      end else begin
        state_reg <= FETCH;
      end
    end else begin
      case (state_reg)
        FETCH: begin
          if (done) begin
            pc_reg      <= pc_plus4;
            pending_reg <= 1'b0;
            if (!IF_stall) begin
              ID_PC_plus4    <= pc_plus4;
              ID_Instruction <= imem_rdata;
              ID_valid       <= 1'b1;
            end else begin
              buf_pc4_reg   <= pc_plus4;
              buf_instr_reg <= imem_rdata;
              state_reg     <= FULL;
            end
          end else begin
            pending_reg <= imem_req;
            if (!IF_stall) begin
              ID_PC_plus4    <= 32'd0;
              ID_Instruction <= 32'd0;
              ID_valid       <= 1'b0;
            end
          end
        end
        DROP: begin
          if (imem_ready) state_reg <= FETCH;
          if (!IF_stall) begin
            ID_PC_plus4    <= 32'd0;
            ID_Instruction <= 32'd0;
            ID_valid       <= 1'b0;
          end
        end
        FULL: begin
          if (!IF_stall) begin
            ID_PC_plus4    <= buf_pc4_reg;
            ID_Instruction <= buf_instr_reg;
            ID_valid       <= 1'b1;
            buf_pc4_reg    <= 32'd0;
            buf_instr_reg  <= 32'd0;
            state_reg      <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: a vector table walks through fetch, stall, redirect and wrap,
// followed by a hand-written asynchronous reset sequence.
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        IF_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] ID_PC_plus4;
  logic [31:0] ID_Instruction;
  logic        ID_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory model: the word at an address is the address xor a fixed pattern.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .IF_stall       (IF_stall),
    .redirect       (redirect),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .ID_PC_plus4    (ID_PC_plus4),
    .ID_Instruction (ID_Instruction),
    .ID_valid       (ID_valid)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] tgt;
    logic        ready;
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc4;
    logic [31:0] instr;
    logic        valid;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs[NV];

  function automatic logic [31:0] iw(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] tg, input logic rdy,
                              input logic rq, input logic [31:0] ad, input logic [31:0] p4,
                              input logic [31:0] ins, input logic vl);
    vec_t r;
    r.stall = st; r.redir = rd; r.tgt = tg; r.ready = rdy;
    r.req = rq; r.addr = ad; r.pc4 = p4; r.instr = ins; r.valid = vl;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic req, input logic [31:0] pc4,
                             input logic [31:0] instr, input logic vl);
    chk({tag, ".imem_req"}, 32'(imem_req), 32'(req));
    chk({tag, ".ID_PC_plus4"}, ID_PC_plus4, pc4);
    chk({tag, ".ID_Instruction"}, ID_Instruction, instr);
    chk({tag, ".ID_valid"}, 32'(ID_valid), 32'(vl));
  endtask

  initial begin
    //             stall redir target        ready req addr          pc4           instr              valid
    vecs[0]  = mk(0, 0, 32'h0,          1, 1, 32'h0000_0000, 32'h0000_0004, iw(32'h0000_0000), 1);
    vecs[1]  = mk(0, 0, 32'h0,          1, 1, 32'h0000_0004, 32'h0000_0008, iw(32'h0000_0004), 1);
    vecs[2]  = mk(1, 0, 32'h0,          0, 0, 32'h0000_0008, 32'h0000_0008, iw(32'h0000_0004), 1);
    vecs[3]  = mk(1, 0, 32'h0,          1, 0, 32'h0000_0008, 32'h0000_0008, iw(32'h0000_0004), 1);
    vecs[4]  = mk(0, 0, 32'h0,          0, 1, 32'h0000_0008, 32'h0,         32'h0,             0);
    vecs[5]  = mk(1, 0, 32'h0,          0, 1, 32'h0000_0008, 32'h0,         32'h0,             0);
    vecs[6]  = mk(1, 0, 32'h0,          1, 1, 32'h0000_0008, 32'h0,         32'h0,             0);
    vecs[7]  = mk(1, 0, 32'h0,          1, 0, 32'h0000_000C, 32'h0,         32'h0,             0);
    vecs[8]  = mk(0, 0, 32'h0,          0, 0, 32'h0000_000C, 32'h0000_000C, iw(32'h0000_0008), 1);
    vecs[9]  = mk(0, 0, 32'h0,          1, 1, 32'h0000_000C, 32'h0000_0010, iw(32'h0000_000C), 1);
    vecs[10] = mk(0, 0, 32'h0,          0, 1, 32'h0000_0010, 32'h0,         32'h0,             0);
    vecs[11] = mk(0, 1, 32'h0000_0100,  0, 1, 32'h0000_0010, 32'h0,         32'h0,             0);
    vecs[12] = mk(0, 0, 32'h0,          0, 1, 32'h0000_0010, 32'h0,         32'h0,             0);
    vecs[13] = mk(0, 0, 32'h0,          1, 1, 32'h0000_0010, 32'h0,         32'h0,             0);
    vecs[14] = mk(0, 0, 32'h0,          1, 1, 32'h0000_0100, 32'h0000_0104, iw(32'h0000_0100), 1);
    vecs[15] = mk(0, 0, 32'h0,          0, 1, 32'h0000_0104, 32'h0,         32'h0,             0);
    vecs[16] = mk(1, 0, 32'h0,          1, 1, 32'h0000_0104, 32'h0,         32'h0,             0);
    vecs[17] = mk(1, 1, 32'h0000_0203,  0, 0, 32'h0000_0108, 32'h0,         32'h0,             0);
    vecs[18] = mk(0, 0, 32'h0,          1, 1, 32'h0000_0200, 32'h0000_0204, iw(32'h0000_0200), 1);
    vecs[19] = mk(0, 1, 32'hFFFF_FFFC,  1, 1, 32'h0000_0204, 32'h0,         32'h0,             0);
    vecs[20] = mk(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC, 32'h0000_0000, iw(32'hFFFF_FFFC), 1);
    vecs[21] = mk(0, 0, 32'h0,          1, 1, 32'h0000_0000, 32'h0000_0004, iw(32'h0000_0000), 1);

    // Reset state, before any clock edge.
    #1;
    chk_outputs("reset", 1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      IF_stall        = vecs[i].stall;
      redirect        = vecs[i].redir;
      redirect_target = vecs[i].tgt;
      imem_ready      = vecs[i].ready;
      #1;
      chk($sformatf("v%0d.imem_req", i), 32'(imem_req), 32'(vecs[i].req));
      chk($sformatf("v%0d.imem_addr", i), imem_addr, vecs[i].addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.ID_PC_plus4", i), ID_PC_plus4, vecs[i].pc4);
      chk($sformatf("v%0d.ID_Instruction", i), ID_Instruction, vecs[i].instr);
      chk($sformatf("v%0d.ID_valid", i), 32'(ID_valid), 32'(vecs[i].valid));
      $display("vec %0d: stall=%0b redir=%0b ready=%0b -> req=%0b addr=%08h pc4=%08h instr=%08h valid=%0b",
               i, vecs[i].stall, vecs[i].redir, vecs[i].ready, vecs[i].req, vecs[i].addr,
               ID_PC_plus4, ID_Instruction, ID_valid);
      @(negedge clk);
    end

    // Asynchronous reset while a fetch at 0x4 is waiting for ready.
    IF_stall   = 1'b0;
    redirect   = 1'b0;
    imem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("wait.imem_req", 32'(imem_req), 32'd1);
    chk("wait.imem_addr", imem_addr, 32'h0000_0004);
    #2;
    reset = 1'b0;
    #1;
    chk_outputs("async_rst", 1'b0, 32'h0, 32'h0, 1'b0);
    chk("async_rst.imem_addr", imem_addr, 32'h0000_0000);
    $display("async reset mid-wait: req=%0b addr=%08h valid=%0b", imem_req, imem_addr, ID_valid);
    @(posedge clk);
    @(negedge clk);
    chk("rst_held.imem_req", 32'(imem_req), 32'd0);
    reset      = 1'b1;
    imem_ready = 1'b1;
    #1;
    chk("release.imem_req", 32'(imem_req), 32'd1);
    chk("release.imem_addr", imem_addr, 32'h0000_0000);
    @(posedge clk);
    #1;
    chk_outputs("release_fetch", 1'b1, 32'h0000_0004, iw(32'h0000_0000), 1'b1);
    $display("first fetch after release: pc4=%08h instr=%08h valid=%0b", ID_PC_plus4, ID_Instruction, ID_valid);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port IF_stall  input  1  hold request from the hazard unit (load-use); IF/ID outputs frozen.
REQ-005 SHALL have port redirect  input  1  branch/jump taken; flush IF/ID and refetch.
REQ-006 SHALL have port redirect_target  input  32  new PC on redirect.
REQ-007 SHALL have port imem_req  output  1  instruction fetch request.
REQ-008 SHALL have port imem_addr  output  32  fetch address.
REQ-009 SHALL have port imem_ready  input  1  fetch complete; imem_rdata valid this cycle.
REQ-010 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-011 SHALL have port ID_PC_plus4  output  32  PC+4 of the instruction in IF/ID, feeding the ID_EX register input ID_PC_plus4.
REQ-012 SHALL have port ID_Instruction  output  32  instruction in IF/ID.
REQ-013 SHALL have port ID_valid  output  1  IF/ID holds a real instruction; 0 means bubble.

Function
REQ-014 SHALL implement a three-state FSM: FETCH (request may issue or be outstanding), DROP (outstanding response must be discarded), FULL (response buffered during stall).
REQ-015 SHALL drive imem_addr from the PC register and assert imem_req in FETCH when IF_stall=0, and in DROP always.
REQ-016 SHALL, once imem_req=1 with imem_ready=0, keep imem_req=1 and imem_addr unchanged until imem_ready=1, regardless of IF_stall; stall only blocks starting a new request.
REQ-017 SHALL, in FETCH on imem_req&imem_ready with IF_stall=0 and redirect=0, load IF/ID with {PC+4, imem_rdata, valid=1} and set PC<=PC+4 on the same edge (1-cycle latency from ready to ID_valid).
REQ-018 SHALL, in FETCH with IF_stall=0, redirect=0 and no completion, load a bubble: ID_valid=0, ID_Instruction=0, ID_PC_plus4=0.
REQ-019 SHALL, while IF_stall=1 and redirect=0, hold ID_PC_plus4, ID_Instruction and ID_valid unchanged.
REQ-020 SHALL, in FETCH on completion with IF_stall=1 and redirect=0, store {PC+4, imem_rdata} in a buffer, set PC<=PC+4, go to FULL.
REQ-021 SHALL, in FULL, hold imem_req=0; on IF_stall=0 and redirect=0, move buffer into IF/ID with valid=1 and go to FETCH.
REQ-022 SHALL, on redirect=1 (any state, priority over IF_stall), set IF/ID to bubble, set PC<=redirect_target with bits [1:0] forced to 0, and discard any buffered word.
REQ-023 SHALL, on redirect with a request outstanding and imem_ready=0 (FETCH or DROP), go to DROP; otherwise go to FETCH.
REQ-024 SHALL, in DROP on imem_ready=1, discard imem_rdata, leave IF/ID as bubble, go to FETCH; PC not incremented.
REQ-025 SHALL, in DROP while redirect=0 and imem_ready=0, load IF/ID with a bubble unless IF_stall=1 (then hold).
REQ-026 SHALL compute PC+4 modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-027 SHALL never deliver an instruction twice nor skip an address between redirects.

Reset
REQ-028 SHALL, on reset=0, immediately force PC=RESET_PC, state=FETCH, ID_PC_plus4=0, ID_Instruction=0, ID_valid=0, buffer cleared, imem_req=0.
REQ-029 SHALL, on reset release, issue the first request (addr RESET_PC) on the first posedge clk with reset=1 and IF_stall=0.
REQ-030 SHALL, on reset asserted mid-fetch, abandon the outstanding request; memory side is reset by the same signal.

Verification
REQ-031 Zero-wait fetch: imem_ready=1 always, rdata=addr^32'hA5A5_0000 -> ID_valid=1 each cycle, ID_PC_plus4 = 4, 8, 12...
REQ-032 Stall with completion: 3-cycle wait on addr 0x8, IF_stall=1 during ready -> state FULL, IF/ID holds previous; IF_stall drops -> ID_PC_plus4=0xC next edge, req for 0xC follows.
REQ-033 Redirect during outstanding fetch: req at 0x10 waiting, redirect=1 target 0x100 -> DROP, addr stays 0x10 until ready, response discarded, next req addr 0x100, ID_valid=0 throughout.
REQ-034 Redirect and stall same cycle in FULL: buffer discarded, ID_valid=0, PC=0x200 (target 0x203 aligned).
REQ-035 Wrap: redirect to 0xFFFF_FFFC, ready=1 -> ID_PC_plus4=0, next addr 0.
REQ-036 Async reset mid-wait: reset=0 between edges -> outputs zero and imem_req=0 without a clock edge; first request after release addr RESET_PC.
